nibble_capture_bank: RTL
========================

NIBBLE_CAPTURE_BANK -- requirements
Module: nibble_capture_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bits per entry, at least 1.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: producer value to capture.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is offered this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the bank accepts this cycle.
REQ-008 SHALL have port flush, input, 1 bit: abandon the current fill.
REQ-009 SHALL have port out_flat, output, DEPTH*WIDTH bits: the concatenation {v[DEPTH-1], ..., v[0]}.
REQ-010 SHALL have port out_valid, output, 1 bit: the bank is full and out_flat is stable.
REQ-011 SHALL have port out_ack, input, 1 bit: the consumer has taken out_flat.
REQ-012 SHALL have port count, output, clog2(DEPTH)+1 bits: number of entries filled.
REQ-013 SHALL have port rd_addr, input, clog2(DEPTH) bits: random-read address.
REQ-014 SHALL have port rd_data, output, WIDTH bits: registered read data.

Function
REQ-015 SHALL store entries in an unpacked array v[DEPTH-1:0] of WIDTH-bit logic, with write pointer wptr.
REQ-016 SHALL implement states EMPTY (count=0), FILL (0<count<DEPTH) and FULL (count=DEPTH).
REQ-017 SHALL drive in_ready=1 in EMPTY and FILL, and in_ready=0 in FULL.
REQ-018 SHALL accept when in_valid && in_ready && !flush: v[wptr]<=in_data; wptr and count increment.
REQ-019 SHALL enter FULL and set out_valid=1 on the cycle after the DEPTH-th accept; wptr wraps to 0.
REQ-020 SHALL, on out_ack in FULL, go to EMPTY with out_valid=0 and count=0 on the next cycle; v contents are retained.
REQ-021 SHALL ignore out_ack outside FULL.
REQ-022 SHALL ignore in_valid in the out_ack cycle, since in_ready=0 in FULL.
REQ-023 SHALL, on flush in any state, go to EMPTY with wptr=0, count=0 and out_valid=0 next cycle; v is untouched.
REQ-024 SHALL give flush priority over a simultaneous accept and a simultaneous out_ack.
REQ-025 SHALL drive out_flat combinationally from v at all times; it is qualified only by out_valid.
REQ-026 SHALL register rd_data<=v[rd_addr] with 1-cycle latency; a read of the entry written in the same cycle returns the old value.
REQ-027 SHALL never let count exceed DEPTH or hold an undefined value.

Reset
REQ-028 SHALL, while rst=1 and asynchronously, set state=EMPTY, wptr=0, count=0, every v entry to 0, out_valid=0 and rd_data=0; in_ready=1 after reset.
REQ-029 SHALL, on reset asserted mid-fill or in FULL, abandon the fill with no out_valid pulse.

Configuration
REQ-030 SHALL, with macro NIBBLE_CAPTURE_BANK_PARITY_EN defined:
- store an even-parity bit per entry at accept time;
- add output out_parity, DEPTH bits, with bit i equal to the parity of v[i];
- reset out_parity to 0.
REQ-031 SHALL, without NIBBLE_CAPTURE_BANK_PARITY_EN, have no out_parity port and no parity storage.

Structure
REQ-032 SHALL place the state enum (EMPTY/FILL/FULL) and the default WIDTH/DEPTH constants in package nibble_capture_pkg.
REQ-033 SHALL use one sub-module, nibble_capture_ctrl: state machine, wptr and count. The array and read port stay in the top module.

Verification
REQ-034 Reset then four accepts of 4'hA (DEPTH=4) -> count=4, out_valid=1 after 4th accept cycle, out_flat=16'hAAAA, in_ready=0.
REQ-035 Accepts 1,2,3,4 then out_ack -> out_flat=16'h4321 while full; next cycle count=0, out_valid=0, in_ready=1, out_flat still 16'h4321.
REQ-036 Two accepts (5,6), flush together with third in_valid (7) -> count=0, v[2] unchanged, no out_valid.
REQ-037 In FULL, hold in_valid=1 with 4'hF for 3 cycles -> no write, out_flat unchanged; then out_ack -> EMPTY.
REQ-038 rd_addr=2 while v[2] is written with 4'h9 -> rd_data shows old value, then 4'h9 one cycle later.
REQ-039 rst pulse mid-fill (count=2) -> all outputs zero immediately, in_ready=1; with PARITY_EN, a value of 4'h7 gives parity bit 1.

Source files
------------

// File: rtl/nibble_capture_pkg.sv
// Shared types and default sizing for the nibble capture bank.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional macro used by the bank: NIBBLE_CAPTURE_BANK_PARITY_EN.
package nibble_capture_pkg;

  localparam int NCB_WIDTH_DEF = 4;
  localparam int NCB_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } ncb_state_e;

endpackage

// File: rtl/nibble_capture_ctrl.sv
// Fill controller: EMPTY/FILL/FULL state, write pointer, entry count, handshake flags.
// Latency: accept -> count/wptr update next cycle; DEPTH-th accept -> out_valid next cycle.
// Backpressure: in_ready drops while FULL until out_ack; flush overrides accept and ack.
module nibble_capture_ctrl
  import nibble_capture_pkg::*;
#(
  parameter int DEPTH = NCB_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic                       flush_i,
  input  logic                       out_ack_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic                       wr_en_o,
  output logic [$clog2(DEPTH)-1:0]   wptr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  ncb_state_e      state_q;
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   wptr_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            in_ready_q;
  logic            out_valid_q;

  // in_ready_q is only high outside FULL, so this is the whole accept rule
  assign wr_en_o = in_valid_i && in_ready_q && !flush_i;

  // Pointer wraps to 0 naturally after the last entry because DEPTH is a power of two
  assign wptr_d  = wptr_q + AW'(1);
  assign count_d = count_q + CW'(1);

  // State machine with registered handshake outputs; flush behaves like a soft reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      wptr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= EMPTY;
      wptr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY, FILL: begin
          if (wr_en_o) begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
            if (count_q == LAST) begin
              state_q     <= FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FULL: begin
          if (out_ack_i) begin
            state_q     <= EMPTY;
            wptr_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          wptr_q      <= '0;
          count_q     <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign wptr_o      = wptr_q;
  assign count_o     = count_q;

endmodule

// File: rtl/nibble_capture_bank.sv
// Captures DEPTH producer words into a bank, presents them flat when full, plus a random-read port.
// Latency: out_valid the cycle after the DEPTH-th accept; rd_data one cycle after rd_addr.
// Backpressure: in_ready low while full until out_ack. Optional NIBBLE_CAPTURE_BANK_PARITY_EN adds out_parity.
module nibble_capture_bank
  import nibble_capture_pkg::*;
#(
  parameter int WIDTH = NCB_WIDTH_DEF,
  parameter int DEPTH = NCB_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [DEPTH*WIDTH-1:0]     out_flat,
  output logic                       out_valid,
  input  logic                       out_ack,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
`ifdef NIBBLE_CAPTURE_BANK_PARITY_EN
  ,
  output logic [DEPTH-1:0]           out_parity
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] v [DEPTH-1:0];
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_en;
  logic [AW-1:0]    wptr;

  nibble_capture_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .flush_i     (flush),
    .out_ack_i   (out_ack),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .wr_en_o     (wr_en),
    .wptr_o      (wptr),
    .count_o     (count)
  );

  // Entry storage: only accepts write; flush and ack leave contents alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        v[i] <= '0;
      end
    end else if (wr_en) begin
      v[wptr] <= in_data;
    end
  end

  // Registered random read; a same-cycle write is not bypassed, so the old value is returned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= v[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

  // Flat view is always live; consumers qualify it with out_valid
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign out_flat[g*WIDTH +: WIDTH] = v[g];
  end

`ifdef NIBBLE_CAPTURE_BANK_PARITY_EN
  logic [DEPTH-1:0] par_q;

  // Even-parity bit captured alongside each accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= '0;
    end else if (wr_en) begin
      par_q[wptr] <= ^in_data;
    end
  end

  assign out_parity = par_q;
`endif

endmodule
